mcoi_link_reset_sequencer: RTL and testbench
============================================

MCOI_LINK_RESET_SEQUENCER -- requirements
Module: mcoi_link_reset_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1024: consecutive synchronised-lock cycles required before leaving WAIT_PLL.
REQ-002 SHALL have parameter TX_RESET_CYCLES, default 16: tx_reset_o pulse length.
REQ-003 SHALL have parameter RX_RESET_CYCLES, default 16: rx_reset_o pulse length.
REQ-004 SHALL have parameter RX_TIMEOUT_CYCLES, default 1000000: maximum WAIT_RX dwell.
REQ-005 SHALL have parameter MAX_RETRIES, default 8: fault limit, used only under MCOI_LINK_SEQ_RETRY_LIMIT_EN.
REQ-006 SHALL have ports, one clock and an asynchronous active-low reset:
 clk_ik  in  1  free-running system clock (100 MHz domain)
 rst_n_ir  in  1  asynchronous active-low reset
 pll_locked_i  in  1  recovered-clock PLL lock; asynchronous
 los_i  in  1  optical loss-of-signal; asynchronous
 rx_ready_i  in  1  GBT RX frame aligned; asynchronous
 tx_disable_o  out  1  SFP transmitter disable
 rate_select_o  out  1  SFP rate select; constant 0
 tx_reset_o  out  1  GBT TX reset, active high
 rx_reset_o  out  1  GBT RX reset, active high
 link_up_o  out  1  link operational
 retry_count_o  out  8  faults since last UP, saturating at 255
 state_o  out  3  current FSM state encoding

Function
REQ-007 SHALL synchronise pll_locked_i, los_i and rx_ready_i with 2-flop synchronisers; all decisions use the synchronised values (2-cycle input latency).
REQ-008 SHALL register all outputs, driven from current state and counters.
REQ-009 SHALL implement the states IDLE=0, WAIT_PLL=1, TX_RST=2, RX_RST=3, WAIT_RX=4, UP=5, FAULT=6, HALT=7.
REQ-010 IDLE: move to WAIT_PLL on the first clock after reset release.
REQ-011 WAIT_PLL: count consecutive lock-high cycles; lock low clears the count; at SETTLE_CYCLES, go to TX_RST.
REQ-012 TX_RST: tx_reset_o=1 for exactly TX_RESET_CYCLES cycles, then go to RX_RST.
REQ-013 RX_RST: rx_reset_o=1; while los is high, hold the counter at 0; after RX_RESET_CYCLES cycles with los low, go to WAIT_RX.
REQ-014 WAIT_RX: rx_ready high moves to UP. Both of the following move to FAULT: los high, or RX_TIMEOUT_CYCLES cycles elapsed.
REQ-015 UP: link_up_o=1 and retry_count_o cleared to 0 on entry; rx_ready low or los high moves to FAULT.
REQ-016 FAULT: single cycle; increment retry_count_o, saturating at 255; go to RX_RST.
REQ-017 Lock low, from any state except IDLE, WAIT_PLL and HALT, goes to WAIT_PLL; it has highest priority over all other transitions in the same cycle.
REQ-018 tx_disable_o=1 in IDLE, WAIT_PLL and HALT; 0 otherwise.
REQ-019 tx_reset_o=1 in IDLE, WAIT_PLL, TX_RST and HALT.
REQ-020 rx_reset_o=1 in all states except WAIT_RX and UP.
REQ-021 Counter widths SHALL be $clog2 of the largest parameter plus 1; counters clear on every state change.

Reset
REQ-022 rst_n_ir low SHALL asynchronously force: state IDLE, state_o=0, tx_disable_o=1, tx_reset_o=1, rx_reset_o=1, link_up_o=0, retry_count_o=0, rate_select_o=0, synchronisers 0.
REQ-023 Reset asserted mid-sequence SHALL abort immediately; release restarts from IDLE.

Configuration
REQ-024 With MCOI_LINK_SEQ_RETRY_LIMIT_EN defined: FAULT with retry_count_o reaching MAX_RETRIES goes to HALT, which is left only by reset. Without the macro: no HALT entry, unlimited retries, and state 7 is unreachable.

Verification (SETTLE=8, TX=4, RX=4, RX_TIMEOUT=32, MAX_RETRIES=3)
REQ-025 Lock high, los low, rx_ready high 40 cycles after reset -> tx_reset_o is 1 for 4 cycles in TX_RST, rx_reset_o falls after RX_RST, link_up_o=1, state_o=5.
REQ-026 Lock toggles low at settle count 5 -> settle restarts; TX_RST is entered only after 8 consecutive high cycles.
REQ-027 In UP, los pulsed high for 10 cycles -> FAULT, retry_count_o=1, RX_RST held until los low plus 4 cycles, then UP and retry_count_o=0.
REQ-028 rx_ready never asserts -> FAULT after 32 cycles in WAIT_RX, repeating; with the macro: HALT (state_o=7), tx_disable_o=1 after 3 faults; without: retry_count_o saturates at 255.
REQ-029 Lock low in the same cycle as FAULT-causing los in UP -> WAIT_PLL, tx_disable_o=1, retry_count_o unchanged.
REQ-030 rst_n_ir pulsed low during TX_RST -> all outputs at reset values in the same cycle; the sequence restarts from IDLE.

Source files
------------

// File: rtl/mcoi_link_reset_sequencer.sv
// Optical link bring-up sequencer: PLL settle, GBT TX/RX reset pulses, RX alignment wait, fault retry.
// Optional MCOI_LINK_SEQ_RETRY_LIMIT_EN: stop in HALT once MAX_RETRIES faults accumulate.
module mcoi_link_reset_sequencer #(
  parameter int unsigned SETTLE_CYCLES     = 1024,
  parameter int unsigned TX_RESET_CYCLES   = 16,
  parameter int unsigned RX_RESET_CYCLES   = 16,
  parameter int unsigned RX_TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_RETRIES       = 8
) (
  input  logic       clk_ik,
  input  logic       rst_n_ir,
  input  logic       pll_locked_i,
  input  logic       los_i,
  input  logic       rx_ready_i,
  output logic       tx_disable_o,
  output logic       rate_select_o,
  output logic       tx_reset_o,
  output logic       rx_reset_o,
  output logic       link_up_o,
  output logic [7:0] retry_count_o,
  output logic [2:0] state_o
);

  localparam int unsigned M1   = (SETTLE_CYCLES > TX_RESET_CYCLES) ? SETTLE_CYCLES : TX_RESET_CYCLES;
  localparam int unsigned M2   = (M1 > RX_RESET_CYCLES) ? M1 : RX_RESET_CYCLES;
  localparam int unsigned M3   = (M2 > RX_TIMEOUT_CYCLES) ? M2 : RX_TIMEOUT_CYCLES;
  localparam int unsigned M4   = (M3 > MAX_RETRIES) ? M3 : MAX_RETRIES;
  localparam int unsigned CW   = $clog2(M4) + 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_PLL = 3'd1,
    TX_RST   = 3'd2,
    RX_RST   = 3'd3,
    WAIT_RX  = 3'd4,
    UP       = 3'd5,
    FAULT    = 3'd6,
    HALT     = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]  retry_q, retry_d;
  logic [1:0]  lock_sync_q, los_sync_q, rdy_sync_q;
  logic        tx_disable_q, tx_reset_q, rx_reset_q, link_up_q;
  logic        lock_s, los_s, rdy_s;

  assign lock_s = lock_sync_q[1];
  assign los_s  = los_sync_q[1];
  assign rdy_s  = rdy_sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    case (state_q)
      IDLE:     state_d = WAIT_PLL;
      WAIT_PLL: begin
        if (!lock_s)                               cnt_d = '0;
        else if (cnt_q == CW'(SETTLE_CYCLES - 1))  state_d = TX_RST;
        else                                       cnt_d = cnt_q + CW'(1);
      end
      TX_RST: begin
        if (cnt_q == CW'(TX_RESET_CYCLES - 1))     state_d = RX_RST;
        else                                       cnt_d = cnt_q + CW'(1);
      end
      RX_RST: begin
        if (los_s)                                 cnt_d = '0;
        else if (cnt_q == CW'(RX_RESET_CYCLES - 1)) state_d = WAIT_RX;
        else                                       cnt_d = cnt_q + CW'(1);
      end
      WAIT_RX: begin
        if (los_s)                                 state_d = FAULT;
        else if (rdy_s)                            state_d = UP;
        else if (cnt_q == CW'(RX_TIMEOUT_CYCLES - 1)) state_d = FAULT;
        else                                       cnt_d = cnt_q + CW'(1);
      end
      UP: begin
        if (!rdy_s || los_s)                       state_d = FAULT;
      end
      FAULT: begin
`ifdef MCOI_LINK_SEQ_RETRY_LIMIT_EN
        if (retry_q >= 8'(MAX_RETRIES))            state_d = HALT;
        else                                       state_d = RX_RST;
`else
        state_d = RX_RST;
`endif
      end
      HALT: begin
`ifdef MCOI_LINK_SEQ_RETRY_LIMIT_EN
        state_d = HALT;
`else
        state_d = IDLE;
`endif
      end
      default:  state_d = IDLE;
    endcase

    // Lock loss overrides every other transition decided above.
    if (!lock_s && !(state_q inside {IDLE, WAIT_PLL, HALT})) state_d = WAIT_PLL;

    // The retry count moves on entry so FAULT already shows the new value.
    if (state_d != state_q) begin
      cnt_d = '0;
      if (state_d == FAULT && retry_q != 8'hFF) retry_d = retry_q + 8'd1;
      if (state_d == UP)                        retry_d = '0;
    end
  end

  always_ff @(posedge clk_ik or negedge rst_n_ir) begin
    if (!rst_n_ir) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      retry_q      <= '0;
      lock_sync_q  <= '0;
      los_sync_q   <= '0;
      rdy_sync_q   <= '0;
      tx_disable_q <= 1'b1;
      tx_reset_q   <= 1'b1;
      rx_reset_q   <= 1'b1;
      link_up_q    <= 1'b0;
    end else begin
      lock_sync_q  <= {lock_sync_q[0], pll_locked_i};
      los_sync_q   <= {los_sync_q[0], los_i};
      rdy_sync_q   <= {rdy_sync_q[0], rx_ready_i};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      tx_disable_q <= state_d inside {IDLE, WAIT_PLL, HALT};
      tx_reset_q   <= state_d inside {IDLE, WAIT_PLL, TX_RST, HALT};
      rx_reset_q   <= !(state_d inside {WAIT_RX, UP});
      link_up_q    <= (state_d == UP);
    end
  end

  assign tx_disable_o  = tx_disable_q;
  assign tx_reset_o    = tx_reset_q;
  assign rx_reset_o    = rx_reset_q;
  assign link_up_o     = link_up_q;
  assign retry_count_o = retry_q;
  assign state_o       = state_q;
  assign rate_select_o = 1'b0;

endmodule

// File: tb/tb_mcoi_link_reset_sequencer.sv
// Directed bench for mcoi_link_reset_sequencer with short timing parameters.
module tb_mcoi_link_reset_sequencer;

  logic       clk_ik = 1'b0;
  logic       rst_n_ir;
  logic       pll_locked_i, los_i, rx_ready_i;
  logic       tx_disable_o, rate_select_o, tx_reset_o, rx_reset_o, link_up_o;
  logic [7:0] retry_count_o;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  mcoi_link_reset_sequencer #(
    .SETTLE_CYCLES(8),
    .TX_RESET_CYCLES(4),
    .RX_RESET_CYCLES(4),
    .RX_TIMEOUT_CYCLES(32),
    .MAX_RETRIES(3)
  ) dut (
    .clk_ik(clk_ik),
    .rst_n_ir(rst_n_ir),
    .pll_locked_i(pll_locked_i),
    .los_i(los_i),
    .rx_ready_i(rx_ready_i),
    .tx_disable_o(tx_disable_o),
    .rate_select_o(rate_select_o),
    .tx_reset_o(tx_reset_o),
    .rx_reset_o(rx_reset_o),
    .link_up_o(link_up_o),
    .retry_count_o(retry_count_o),
    .state_o(state_o)
  );

  always #5 clk_ik = ~clk_ik;

  task automatic tick();
    @(posedge clk_ik);
    #1;
  endtask

  // Applies reset for two edges; release lands 1 time unit after an edge.
  task automatic do_reset(input logic lock, input logic rdy);
    rst_n_ir = 1'b0;
    pll_locked_i = lock;
    los_i = 1'b0;
    rx_ready_i = rdy;
    tick();
    tick();
    rst_n_ir = 1'b1;
  endtask

  task automatic test_reset();
    rst_n_ir = 1'b0;
    pll_locked_i = 1'b1;
    los_i = 1'b0;
    rx_ready_i = 1'b0;
    tick();
    tick();
    checks++; if (state_o !== 3'd0)       begin errors++; $display("FAIL rst_state got %0d exp 0", state_o); end
    checks++; if (tx_disable_o !== 1'b1)  begin errors++; $display("FAIL rst_txdis got %0b exp 1", tx_disable_o); end
    checks++; if (tx_reset_o !== 1'b1)    begin errors++; $display("FAIL rst_txrst got %0b exp 1", tx_reset_o); end
    checks++; if (rx_reset_o !== 1'b1)    begin errors++; $display("FAIL rst_rxrst got %0b exp 1", rx_reset_o); end
    checks++; if (link_up_o !== 1'b0)     begin errors++; $display("FAIL rst_linkup got %0b exp 0", link_up_o); end
    checks++; if (retry_count_o !== 8'd0) begin errors++; $display("FAIL rst_retry got %0d exp 0", retry_count_o); end
    checks++; if (rate_select_o !== 1'b0) begin errors++; $display("FAIL rst_rate got %0b exp 0", rate_select_o); end
  endtask

  task automatic test_bringup();
    int n;
    logic bad;
    do_reset(1'b1, 1'b0);
    tick();
    checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL idle_exit got %0d exp 1", state_o); end
    n = 1;
    while (state_o !== 3'd2 && n < 100) begin tick(); n++; end
    checks++; if (n !== 10) begin errors++; $display("FAIL settle_latency got %0d exp 10", n); end
    n = 0; bad = 1'b0;
    do begin
      if (tx_reset_o !== 1'b1) bad = 1'b1;
      tick(); n++;
    end while (state_o === 3'd2 && n < 50);
    checks++; if (n !== 4) begin errors++; $display("FAIL tx_rst_len got %0d exp 4", n); end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL tx_rst_level got %0b exp 0", bad); end
    checks++; if (state_o !== 3'd3 || tx_reset_o !== 1'b0) begin
      errors++; $display("FAIL rx_rst_entry got st=%0d txrst=%0b exp st=3 txrst=0", state_o, tx_reset_o); end
    n = 0;
    do begin tick(); n++; end while (state_o === 3'd3 && n < 50);
    checks++; if (n !== 4) begin errors++; $display("FAIL rx_rst_len got %0d exp 4", n); end
    checks++; if (state_o !== 3'd4 || rx_reset_o !== 1'b0 || tx_disable_o !== 1'b0) begin
      errors++; $display("FAIL wait_rx_entry got st=%0d rxrst=%0b txdis=%0b exp 4 0 0", state_o, rx_reset_o, tx_disable_o); end
    bad = 1'b0;
    for (int i = 0; i < 22; i++) begin tick(); if (state_o !== 3'd4) bad = 1'b1; end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL wait_rx_hold got %0b exp 0", bad); end
    rx_ready_i = 1'b1;
    tick(); tick();
    checks++; if (state_o !== 3'd4) begin errors++; $display("FAIL rdy_sync_lat got %0d exp 4", state_o); end
    tick();
    checks++; if (state_o !== 3'd5 || link_up_o !== 1'b1 || retry_count_o !== 8'd0) begin
      errors++; $display("FAIL up_entry got st=%0d up=%0b retry=%0d exp 5 1 0", state_o, link_up_o, retry_count_o); end
  endtask

  task automatic test_settle_restart();
    int n;
    do_reset(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    pll_locked_i = 1'b0;
    tick();
    pll_locked_i = 1'b1;
    n = 6;
    while (state_o !== 3'd2 && n < 100) begin tick(); n++; end
    checks++; if (n !== 16) begin errors++; $display("FAIL settle_restart got %0d exp 16", n); end
  endtask

  task automatic test_los_fault();
    int n;
    do_reset(1'b1, 1'b1);
    n = 0;
    while (state_o !== 3'd5 && n < 100) begin tick(); n++; end
    checks++; if (n !== 19) begin errors++; $display("FAIL up_reach got %0d exp 19", n); end
    los_i = 1'b1;
    tick(); tick(); tick();
    checks++; if (state_o !== 3'd6 || retry_count_o !== 8'd1) begin
      errors++; $display("FAIL los_fault got st=%0d retry=%0d exp 6 1", state_o, retry_count_o); end
    tick();
    checks++; if (state_o !== 3'd3 || rx_reset_o !== 1'b1 || link_up_o !== 1'b0 || retry_count_o !== 8'd1) begin
      errors++; $display("FAIL fault_to_rxrst got st=%0d rxrst=%0b up=%0b retry=%0d exp 3 1 0 1",
                         state_o, rx_reset_o, link_up_o, retry_count_o); end
    for (int i = 0; i < 6; i++) tick();
    los_i = 1'b0;
    checks++; if (state_o !== 3'd3) begin errors++; $display("FAIL los_hold got %0d exp 3", state_o); end
    n = 0;
    do begin tick(); n++; end while (state_o === 3'd3 && n < 50);
    checks++; if (n !== 6 || state_o !== 3'd4) begin
      errors++; $display("FAIL los_release got n=%0d st=%0d exp 6 4", n, state_o); end
    tick();
    checks++; if (state_o !== 3'd5 || retry_count_o !== 8'd0 || link_up_o !== 1'b1) begin
      errors++; $display("FAIL reup got st=%0d retry=%0d up=%0b exp 5 0 1", state_o, retry_count_o, link_up_o); end
  endtask

  task automatic test_lock_priority();
    logic saw_fault;
    saw_fault = 1'b0;
    pll_locked_i = 1'b0;
    los_i = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); if (state_o === 3'd6) saw_fault = 1'b1; end
    checks++; if (state_o !== 3'd1 || tx_disable_o !== 1'b1 || link_up_o !== 1'b0) begin
      errors++; $display("FAIL lock_prio got st=%0d txdis=%0b up=%0b exp 1 1 0", state_o, tx_disable_o, link_up_o); end
    checks++; if (retry_count_o !== 8'd0 || saw_fault !== 1'b0) begin
      errors++; $display("FAIL lock_prio_retry got retry=%0d fault=%0b exp 0 0", retry_count_o, saw_fault); end
    pll_locked_i = 1'b1;
    los_i = 1'b0;
  endtask

  task automatic test_reset_in_tx();
    int n;
    do_reset(1'b1, 1'b0);
    n = 0;
    while (state_o !== 3'd2 && n < 100) begin tick(); n++; end
    tick();
    #2;
    rst_n_ir = 1'b0;
    #1;
    checks++; if (state_o !== 3'd0 || tx_disable_o !== 1'b1 || tx_reset_o !== 1'b1 || rx_reset_o !== 1'b1 ||
                  link_up_o !== 1'b0 || retry_count_o !== 8'd0 || rate_select_o !== 1'b0) begin
      errors++; $display("FAIL async_rst got st=%0d txdis=%0b txrst=%0b rxrst=%0b up=%0b retry=%0d exp 0 1 1 1 0 0",
                         state_o, tx_disable_o, tx_reset_o, rx_reset_o, link_up_o, retry_count_o); end
    tick();
    rst_n_ir = 1'b1;
    tick();
    n = 1;
    checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL restart_idle got %0d exp 1", state_o); end
    while (state_o !== 3'd2 && n < 100) begin tick(); n++; end
    checks++; if (n !== 10) begin errors++; $display("FAIL restart_settle got %0d exp 10", n); end
  endtask

  task automatic test_retry();
    int n;
    logic bad;
    do_reset(1'b1, 1'b0);
    n = 0;
    while (state_o !== 3'd4 && n < 100) begin tick(); n++; end
    n = 0;
    do begin tick(); n++; end while (state_o === 3'd4 && n < 100);
    checks++; if (n !== 32 || state_o !== 3'd6 || retry_count_o !== 8'd1) begin
      errors++; $display("FAIL timeout got n=%0d st=%0d retry=%0d exp 32 6 1", n, state_o, retry_count_o); end
    tick();
    checks++; if (state_o !== 3'd3) begin errors++; $display("FAIL timeout_rxrst got %0d exp 3", state_o); end
`ifdef MCOI_LINK_SEQ_RETRY_LIMIT_EN
    n = 0;
    while (state_o !== 3'd7 && n < 300) begin tick(); n++; end
    checks++; if (state_o !== 3'd7 || tx_disable_o !== 1'b1 || retry_count_o !== 8'd3) begin
      errors++; $display("FAIL halt got st=%0d txdis=%0b retry=%0d exp 7 1 3", state_o, tx_disable_o, retry_count_o); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (state_o !== 3'd7) begin errors++; $display("FAIL halt_stay got %0d exp 7", state_o); end
`else
    n = 0; bad = 1'b0;
    while (retry_count_o !== 8'd255 && n < 12000) begin tick(); n++; if (state_o === 3'd7) bad = 1'b1; end
    checks++; if (retry_count_o !== 8'd255) begin errors++; $display("FAIL retry_sat got %0d exp 255", retry_count_o); end
    tick();
    n = 0;
    while (state_o !== 3'd6 && n < 100) begin tick(); n++; end
    checks++; if (state_o !== 3'd6 || retry_count_o !== 8'd255) begin
      errors++; $display("FAIL retry_hold got st=%0d retry=%0d exp 6 255", state_o, retry_count_o); end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL no_halt got %0b exp 0", bad); end
`endif
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_settle_restart();
    test_los_fault();
    test_lock_priority();
    test_reset_in_tx();
    test_retry();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
